keypad_scanner_4x4: RTL

//  Scans a 4x4 matrix keypad: drives one column low at a time, samples active-low rows,

---
 rtl/keypad_scanner_4x4.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/keypad_scanner_4x4.sv
// 4x4 matrix keypad scanner: walks a low column across the keypad on scan_tick,
// debounces press and release, and offers the key code over a valid/ack handshake.
module keypad_scanner_4x4 #(
    parameter int DEBOUNCE_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scan_tick,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ack,
    output logic       key_down,
    output logic       overrun
);

    // Handshake: key_code is offered while key_valid=1; the consumer takes it in any
    // cycle with key_ack=1. key_ack while key_valid=0 has no effect.

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_TICKS - 1);

    state_t     state;
    logic [1:0] col;
    logic [1:0] row_cap;
    logic [3:0] cnt;
    logic [3:0] rows_m;
    logic [3:0] rows_s;

    logic       any_low;
    logic [1:0] low_idx;
    logic       cap_low;
    logic       confirm;
    logic [1:0] col_next;

    function automatic logic [3:0] col_mask(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    always_comb begin
        any_low  = ~&rows_s;
        cap_low  = ~rows_s[row_cap];
        col_next = col + 2'd1;
        if (!rows_s[0])      low_idx = 2'd0;
        else if (!rows_s[1]) low_idx = 2'd1;
        else if (!rows_s[2]) low_idx = 2'd2;
        else                 low_idx = 2'd3;
        confirm = scan_tick && (state == DEBOUNCE) && cap_low && (cnt == CNT_LAST);
    end

    // Two-flop synchronizer; idle keypad reads all-ones because of the pull-ups.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_m <= 4'hF;
            rows_s <= 4'hF;
        end else begin
            rows_m <= row_in;
            rows_s <= rows_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SCAN;
            col       <= 2'd0;
            col_out   <= 4'b1110;
            row_cap   <= 2'd0;
            cnt       <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (scan_tick) begin
                case (state)
                    SCAN: begin
                        if (any_low) begin
                            row_cap <= low_idx;
                            cnt     <= 4'd0;
                            state   <= DEBOUNCE;
                        end else begin
                            col     <= col_next;
                            col_out <= col_mask(col_next);
                        end
                    end
                    DEBOUNCE: begin
                        if (cap_low) begin
                            if (cnt == CNT_LAST) begin
                                state    <= HOLD;
                                key_down <= 1'b1;
                                cnt      <= 4'd0;
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            state   <= SCAN;
                            col     <= col_next;
                            col_out <= col_mask(col_next);
                        end
                    end
                    HOLD: begin
                        // cnt counts consecutive released ticks; any press restarts it.
                        if (!cap_low) begin
                            if (cnt == CNT_LAST) begin
                                state    <= SCAN;
                                key_down <= 1'b0;
                                cnt      <= 4'd0;
                                col      <= col_next;
                                col_out  <= col_mask(col_next);
                            end else begin
                                cnt <= cnt + 4'd1;
                            end
                        end else begin
                            cnt <= 4'd0;
                        end
                    end
                    default: begin
                        state <= SCAN;
                    end
                endcase
            end

            if (key_valid && key_ack) begin
                key_valid <= 1'b0;
                overrun   <= 1'b0;
            end
            // A confirm overrides the ack-driven clear; a blocked one only flags overrun.
            if (confirm) begin
                if (!key_valid || key_ack) begin
                    key_code  <= {row_cap, col};
                    key_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end
        end
    end

endmodule
